// File: rtl/mem_wb_stage.sv
// Memory access + MEM/WB pipeline register for a 5-stage RV32 core.
// Latency: write-back fields are registered 1 cycle after the completing cycle.
// Backpressure: StallM freezes upstream while a memory access is outstanding.
//
// Ports:
//   clk, reset                - clock, async active-high reset
//   validM .. upimmM          - EX/MEM slot contents (held stable while StallM=1)
//   dmem_*                    - data memory request/response (req/ready handshake)
//   StallM                    - freeze upstream stages
//   RegWriteW, RDW, ResultW   - register-file write-back
//   misalignW, buserrW        - one-cycle exception pulses
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  LoadM,
    input  logic [1:0]  StoreM,
    input  logic [4:0]  RDM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] upimmM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        misalignW,
    output logic        buserrW
);

    localparam logic [7:0] LP_TIMEOUT = TIMEOUT[7:0];

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [1:0]  w_off;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_wait;
    logic        w_issue;
    logic        w_abort;
    logic        w_done;
    logic        w_misalign_ev;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic [31:0] w_result;

    assign w_off    = ALUResultM[1:0];
    assign w_mem_op = validM & (MemWriteM | (ResultSrcM == 2'b01));
    assign w_wait   = (r_state == S_WAIT);

    // Natural-alignment check; byte accesses are never misaligned.
    always_comb begin
        w_misalign = 1'b0;
        if (MemWriteM) begin
            case (StoreM)
                2'b00:   w_misalign = |w_off;
                2'b01:   w_misalign = w_off[0];
                default: w_misalign = 1'b0;
            endcase
        end else begin
            case (LoadM)
                3'b000:         w_misalign = |w_off;
                3'b001, 3'b010: w_misalign = w_off[0];
                default:        w_misalign = 1'b0;
            endcase
        end
    end

    // Byte enables and lane-replicated store data for the issue cycle.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (MemWriteM) begin
            case (StoreM)
                2'b01: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                2'b10: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteDataM;
                end
            endcase
        end
    end

    assign w_issue       = (r_state == S_IDLE) & w_mem_op & ~w_misalign;
    assign w_misalign_ev = (r_state == S_IDLE) & w_mem_op & w_misalign;
    // Abort cycle releases StallM so the aborted instruction leaves EX/MEM.
    assign w_abort       = w_wait & ~dmem_ready & (r_cnt == LP_TIMEOUT);
    assign w_done        = ((r_state == S_IDLE) & validM & ~w_mem_op)
                         | (w_issue & dmem_ready)
                         | (w_wait & dmem_ready);

    assign StallM   = ~reset & ((w_issue & ~dmem_ready) | (w_wait & ~dmem_ready & ~w_abort));
    assign dmem_req = ~reset & (w_issue | w_wait);

    // In WAIT the request comes from the latched copy taken at issue.
    always_comb begin
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_be    = 4'd0;
        if (dmem_req) begin
            if (w_wait) begin
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                dmem_be    = r_be;
            end else begin
                dmem_we    = MemWriteM;
                dmem_addr  = {ALUResultM[31:2], 2'b00};
                dmem_wdata = w_wdata;
                dmem_be    = w_be;
            end
        end
    end

    // Load extraction: align the addressed lane down to bit 0, then extend.
    assign w_shifted = dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        case (LoadM)
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = {16'd0, w_shifted[15:0]};
            3'b011:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        case (ResultSrcM)
            2'b00:   w_result = ALUResultM;
            2'b01:   w_result = w_load;
            2'b10:   w_result = PCPlus4M;
            default: w_result = upimmM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            RegWriteW <= 1'b0;
            RDW       <= 5'd0;
            ResultW   <= 32'd0;
            misalignW <= 1'b0;
            buserrW   <= 1'b0;
        end else begin
            misalignW <= w_misalign_ev;
            buserrW   <= w_abort;

            if (w_done) begin
                RegWriteW <= RegWriteM & (|RDM);
                RDW       <= RDM;
                ResultW   <= w_result;
            end else begin
                RegWriteW <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue & ~dmem_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd0;
                        r_we    <= MemWriteM;
                        r_addr  <= {ALUResultM[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready | w_abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
